// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: MSB-first, one bit per clock, idle level 0, optional inter-word gap.
// Optional even-parity bit after each word when SER_PARITY_EN is defined.
module bit_serializer #(
    parameter int WIDTH    = 8,
    parameter int IDLE_GAP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             busy,
    output logic             frame_start
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [7:0] GAP_LAST = 8'((IDLE_GAP > 0) ? (IDLE_GAP - 1) : 0);
    localparam bit HAS_GAP = (IDLE_GAP > 0);

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2, GAP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd3} state_t;
`endif

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [7:0]       gap_cnt, gap_cnt_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic             x_nxt;
    logic             fs_nxt;
    logic             final_cycle;
    logic             gap_done;
    logic             take;
    logic             load;
`ifdef SER_PARITY_EN
    logic             par, par_nxt;
`endif

    // Final emit cycle of a frame and end-of-gap detection drive the ready window.
    always_comb begin
`ifdef SER_PARITY_EN
        final_cycle = (state == PARITY);
`else
        final_cycle = (state == SHIFT) && (bit_cnt == LAST_BIT);
`endif
        gap_done  = (state == GAP) && (gap_cnt == GAP_LAST);
        din_ready = !rst && ((state == IDLE) ||
                             (!HAS_GAP && final_cycle) ||
                             (HAS_GAP && gap_done));
        take      = din_valid && din_ready;
    end

    // Next-state and next-output computation.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
        sreg_nxt    = sreg;
        x_nxt       = 1'b0;
        fs_nxt      = 1'b0;
        load        = 1'b0;
`ifdef SER_PARITY_EN
        par_nxt     = par;
`endif
        case (state)
            IDLE: begin
                load = take;
            end
            SHIFT: begin
                if (bit_cnt != LAST_BIT) begin
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    sreg_nxt    = {sreg[WIDTH-2:0], 1'b0};
                    x_nxt       = sreg[WIDTH-2];
                end else begin
                    bit_cnt_nxt = '0;
`ifdef SER_PARITY_EN
                    state_nxt   = PARITY;
                    x_nxt       = par;
`else
                    if (HAS_GAP) begin
                        state_nxt   = GAP;
                        gap_cnt_nxt = 8'd0;
                    end else begin
                        state_nxt = IDLE;
                        load      = take;
                    end
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                if (HAS_GAP) begin
                    state_nxt   = GAP;
                    gap_cnt_nxt = 8'd0;
                end else begin
                    state_nxt = IDLE;
                    load      = take;
                end
            end
`endif
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt   = IDLE;
                    gap_cnt_nxt = 8'd0;
                    load        = take;
                end else begin
                    gap_cnt_nxt = gap_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // A transfer overrides the idle fallback so back-to-back frames have no bubble.
        if (load) begin
            state_nxt   = SHIFT;
            bit_cnt_nxt = '0;
            sreg_nxt    = din;
            x_nxt       = din[WIDTH-1];
            fs_nxt      = 1'b1;
`ifdef SER_PARITY_EN
            par_nxt     = ^din;
`endif
        end else begin
            fs_nxt = 1'b0;
        end
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            gap_cnt     <= 8'd0;
            sreg        <= '0;
            x           <= 1'b0;
            busy        <= 1'b0;
            frame_start <= 1'b0;
`ifdef SER_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            gap_cnt     <= gap_cnt_nxt;
            sreg        <= sreg_nxt;
            x           <= x_nxt;
            busy        <= (state_nxt != IDLE);
            frame_start <= fs_nxt;
`ifdef SER_PARITY_EN
            par         <= par_nxt;
`endif
        end
    end

endmodule
